// File: rtl/midori_pkg.sv
// Shared definitions for the Midori-128 round datapath.
//   state_t     : 128-bit cipher state, cell 0 in bits [127:120]
//   BETA        : round constants beta_0..beta_18, MSB maps to cell 0
//   SHUFFLE     : ShuffleCell table, output cell i takes input cell SHUFFLE[i]
//   cell_msb()  : MSB bit position of byte cell i within a state_t
package midori_pkg;

    localparam int unsigned BETA_COUNT = 19;
    localparam int unsigned NUM_CELLS  = 16;

    typedef logic [127:0] state_t;

    localparam logic [15:0] BETA [BETA_COUNT] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F, 16'hD170, 16'h0266,
        16'h0BCC, 16'h9481, 16'h40B8, 16'h7197, 16'h228E, 16'h5130, 16'hF8CA,
        16'hDF90, 16'h7C81, 16'h1C24, 16'h23B4, 16'h628A
    };

    localparam int unsigned SHUFFLE [NUM_CELLS] = '{
        0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8
    };

    function automatic int unsigned cell_msb(input int unsigned i);
        return 127 - 8 * i;
    endfunction

endpackage

// File: rtl/midori_round_lin.sv
// Combinational linear layer of one Midori-128 round.
//   state_s   : state after SubCell
//   sub_key   : round key for this round
//   state_out : MixColumn(ShuffleCell(state_s)) ^ sub_key
module midori_round_lin
    import midori_pkg::*;
(
    input  logic [127:0] state_s,
    input  logic [127:0] sub_key,
    output logic [127:0] state_out
);

    logic [7:0] sh_c [NUM_CELLS];
    logic [7:0] mx_c [NUM_CELLS];
    logic [7:0] col_x;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            sh_c[i] = state_s[cell_msb(SHUFFLE[i]) -: 8];
        end

        // Each output byte is the XOR of the other three in its column,
        // i.e. column parity XOR the byte itself.
        col_x = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            col_x = sh_c[4*c] ^ sh_c[4*c+1] ^ sh_c[4*c+2] ^ sh_c[4*c+3];
            for (int unsigned j = 0; j < 4; j++) begin
                mx_c[4*c+j] = col_x ^ sh_c[4*c+j];
            end
        end

        state_out = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            state_out[cell_msb(i) -: 8] = mx_c[i] ^ sub_key[cell_msb(i) -: 8];
        end
    end

endmodule

// File: rtl/midori_round_datapath.sv
// Registered linear half of a Midori-128 encryption round.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : state_s / round_idx / key valid this cycle
//   round_idx  : round counter; 1..19 select beta[round_idx-1], others add no constant
//   key        : cipher key K
//   state_s    : state after SubCell
//   out_valid  : state_next updated on the previous edge
//   state_next : registered MixColumn(ShuffleCell(state_s)) ^ sub_key, holds when idle
//   sub_key    : combinational round key (unaffected by reset)
module midori_round_datapath
    import midori_pkg::*;
#(
    parameter int unsigned NR_CONST = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [4:0]   round_idx,
    input  logic [127:0] key,
    input  logic [127:0] state_s,
    output logic         out_valid,
    output logic [127:0] state_next,
    output logic [127:0] sub_key
);

    localparam logic [4:0] LAST_ROUND = 5'(NR_CONST);

    logic [15:0]  beta;
    logic [127:0] expanded;
    logic [127:0] lin_out;

    always_comb begin
        beta = '0;
        if (round_idx != 5'd0 && round_idx <= LAST_ROUND) begin
            beta = BETA[round_idx - 5'd1];
        end
        // Bit j of beta (counted from the MSB) lands in the LSB of cell j.
        expanded = '0;
        for (int unsigned j = 0; j < NUM_CELLS; j++) begin
            expanded[cell_msb(j) - 7] = beta[15 - j];
        end
        sub_key = key ^ expanded;
    end

    midori_round_lin u_lin (
        .state_s   (state_s),
        .sub_key   (sub_key),
        .state_out (lin_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            state_next <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state_next <= lin_out;
            end
        end
    end

endmodule

// File: tb/tb_midori_round_datapath.sv
module tb_midori_round_datapath;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [4:0]   round_idx;
    logic [127:0] key;
    logic [127:0] state_s;
    logic         out_valid;
    logic [127:0] state_next;
    logic [127:0] sub_key;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    midori_round_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .round_idx  (round_idx),
        .key        (key),
        .state_s    (state_s),
        .out_valid  (out_valid),
        .state_next (state_next),
        .sub_key    (sub_key)
    );

    localparam logic [127:0] K1 = 128'h0123456789ABCDEFFEDCBA9876543210;

    // Independent reference model
    logic [15:0] tb_beta [19] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F, 16'hD170, 16'h0266,
        16'h0BCC, 16'h9481, 16'h40B8, 16'h7197, 16'h228E, 16'h5130, 16'hF8CA,
        16'hDF90, 16'h7C81, 16'h1C24, 16'h23B4, 16'h628A
    };
    int tb_perm [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};

    function automatic logic [127:0] model_key(input logic [127:0] k, input int r);
        logic [127:0] e;
        logic [15:0]  b;
        e = '0;
        if (r >= 1 && r <= 19) begin
            b = tb_beta[r-1];
            for (int j = 0; j < 16; j++) e[120 - 8*j] = b[15 - j];
        end
        return k ^ e;
    endfunction

    function automatic logic [127:0] model_lin(input logic [127:0] s);
        logic [7:0]   c [16];
        logic [7:0]   p [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) c[i] = s[127 - 8*i -: 8];
        for (int i = 0; i < 16; i++) p[i] = c[tb_perm[i]];
        for (int k = 0; k < 16; k += 4) begin
            o[127 - 8*k       -: 8] = p[k+1] ^ p[k+2] ^ p[k+3];
            o[127 - 8*(k+1)   -: 8] = p[k]   ^ p[k+2] ^ p[k+3];
            o[127 - 8*(k+2)   -: 8] = p[k]   ^ p[k+1] ^ p[k+3];
            o[127 - 8*(k+3)   -: 8] = p[k]   ^ p[k+1] ^ p[k+2];
        end
        return o;
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        name;
        logic [127:0] s;
        logic [127:0] k;
        logic [4:0]   r;
        logic [127:0] exp_key;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vecs [7];
    logic [127:0] held;
    logic [127:0] s_tmp;

    initial begin
        vecs[0] = '{"shuffle_only", 128'h000102030405060708090A0B0C0D0E0F, '0, 5'd0,
                    '0, 128'h000A050F0E040B0109030C06070D0208};
        vecs[1] = '{"mixcolumn", 128'h01020408000000000000000000000000, '0, 5'd0,
                    '0, 128'h00010101020202000800080804040004};
        vecs[2] = '{"round1_const", '0, '0, 5'd1,
                    128'h00000001000100010100010100000101, 128'h00000001000100010100010100000101};
        vecs[3] = '{"round19_const", '0, '0, 5'd19,
                    128'h00010100000001000100000001000100, 128'h00010100000001000100000001000100};
        vecs[4] = '{"key_pass_r20", '0, K1, 5'd20, K1, K1};
        vecs[5] = '{"key_pass_r31", '0, K1, 5'd31, K1, K1};
        vecs[6] = '{"key_plus_data_r0", 128'h000102030405060708090A0B0C0D0E0F, K1, 5'd0,
                    K1, 128'h0129406887AFC6EEF7DFB69E71593018};

        rst = 1'b1; in_valid = 1'b0; round_idx = '0; key = '0; state_s = '0;
        tick(); tick();
        check128("reset_state_next", state_next, '0);
        check1("reset_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        tick();
        check1("idle_out_valid", out_valid, 1'b0);

        for (int i = 0; i < 7; i++) begin
            state_s = vecs[i].s; key = vecs[i].k; round_idx = vecs[i].r; in_valid = 1'b1;
            #1;
            check128({vecs[i].name, "_subkey"}, sub_key, vecs[i].exp_key);
            tick();
            check128({vecs[i].name, "_out"}, state_next, vecs[i].exp_out);
            check1({vecs[i].name, "_valid"}, out_valid, 1'b1);
        end

        // Back-to-back rounds 1..19
        for (int r = 1; r <= 19; r++) begin
            s_tmp = {16{8'(r * 7 + 3)}} ^ 128'h5A3C_96E1_0F87_D24B_1E2D_3C4B_5A69_7887;
            state_s = s_tmp; key = K1; round_idx = 5'(r); in_valid = 1'b1;
            tick();
            check128($sformatf("stream_r%0d", r), state_next, model_lin(s_tmp) ^ model_key(K1, r));
            check1($sformatf("stream_valid_r%0d", r), out_valid, 1'b1);
        end

        // Hold while idle, with pulses separated by gaps
        held = state_next;
        in_valid = 1'b0; state_s = ~state_s; round_idx = 5'd3;
        tick();
        check1("gap_valid0", out_valid, 1'b0);
        check128("gap_hold0", state_next, held);
        tick();
        check128("gap_hold1", state_next, held);
        for (int p = 0; p < 6; p++) begin
            s_tmp = {4{32'hC0DE_0000 | 32'(p)}};
            state_s = s_tmp; round_idx = 5'(p + 4); key = ~K1;
            in_valid = (p % 2 == 0);
            if (in_valid) held = model_lin(s_tmp) ^ model_key(~K1, p + 4);
            tick();
            check1($sformatf("pulse_valid%0d", p), out_valid, (p % 2 == 0));
            check128($sformatf("pulse_data%0d", p), state_next, held);
        end

        // Reset wins over a coincident valid input
        state_s = vecs[0].s; key = '0; round_idx = 5'd0; in_valid = 1'b1; rst = 1'b1;
        tick();
        check128("rst_prio_data", state_next, '0);
        check1("rst_prio_valid", out_valid, 1'b0);
        check128("rst_subkey_comb", sub_key, '0);
        round_idx = 5'd1;
        #1;
        check128("rst_subkey_live", sub_key, vecs[2].exp_key);
        round_idx = 5'd0;
        rst = 1'b0;
        tick();
        check128("post_rst_data", state_next, vecs[0].exp_out);
        check1("post_rst_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        check1("final_idle_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
